// File: rtl/vc_local_switch_arbiter_pkg.sv
// Shared constants and state encoding for the per-port
// switch-allocator first stage (local VC arbiter).
package vc_local_switch_arbiter_pkg;

    localparam int V_DEF  = 4;
    localparam int P_DEF  = 5;
    localparam int PW_DEF = $clog2(P_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/vc_local_switch_arbiter_rr.sv
// Combinational round-robin pick: first set bit of req at
// or after ptr (cyclic), as one-hot grant plus index.
module rr_arbiter_v #(
    parameter int V  = 4,
    parameter int VW = $clog2(V)
) (
    input  logic [V-1:0]  req,
    input  logic [VW-1:0] ptr,
    output logic [V-1:0]  gnt,
    output logic [VW-1:0] idx,
    output logic          any
);

    int   j;
    logic found;

    // scan from ptr upwards with wrap, keep the first hit
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < V; i++) begin
            j = (int'(ptr) + i) % V;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = VW'(j);
            end
        end
        any = found;
    end

endmodule

// File: rtl/vc_local_switch_arbiter.sv
// Local VC arbiter for one input port: picks a VC round-robin,
// requests the main allocator, drives crossbar select on grant.
module vc_local_switch_arbiter
    import vc_local_switch_arbiter_pkg::*;
#(
    parameter int V  = V_DEF,
    parameter int P  = P_DEF,
    parameter int PW = $clog2(P)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [V-1:0]  vc_req,
    input  logic [V*PW-1:0] vc_oport,
    output logic          gsa_req,
    output logic [PW-1:0] gsa_oport,
    input  logic          gsa_gnt,
    output logic [V-1:0]  vc_pop,
    output logic [V-1:0]  sel,
    output logic          st_valid
);

    localparam int VW = $clog2(V);

    state_t        state_q;
    state_t        state_d;
    logic [VW-1:0] ptr;
    logic [VW-1:0] ptr_d;
    logic [VW-1:0] win_q;
    logic [VW-1:0] win_d;
    logic [VW-1:0] win_inc;
    logic [V-1:0]  win_oh;
    logic [V-1:0]  sel_q;
    logic [V-1:0]  sel_d;
    logic          pend;
    logic          fire;
    logic          gnt_err;

    logic [V-1:0]  arb_req;
    logic [VW-1:0] arb_ptr;
    logic [V-1:0]  arb_gnt;
    logic [VW-1:0] arb_idx;
    logic          arb_any;

    assign win_oh  = {{(V-1){1'b0}}, 1'b1} << win_q;
    assign win_inc = (win_q == VW'(V-1)) ? '0 : win_q + 1'b1;

    // request is live only while the chosen VC still has flit+credit
    assign pend    = (state_q == REQ) && vc_req[win_q];
    assign fire    = pend && gsa_gnt;
    assign gnt_err = gsa_gnt && !gsa_req;

    assign gsa_req   = pend;
    assign gsa_oport = (state_q == REQ) ?
                       vc_oport[int'(win_q)*PW +: PW] : '0;

    // on grant the winner is masked out and the search starts past it
    assign arb_req = fire ? (vc_req & ~win_oh) : vc_req;
    assign arb_ptr = fire ? win_inc : ptr;

    rr_arbiter_v #(
        .V  (V),
        .VW (VW)
    ) u_rr (
        .req (arb_req),
        .ptr (arb_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign sel      = sel_q;
    assign vc_pop   = sel_q;
    assign st_valid = |sel_q;

    // next state, winner, pointer and crossbar select
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr;
        sel_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    win_d   = arb_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (fire) begin
                    sel_d = win_oh;
                    ptr_d = win_inc;
                    if (arb_any) begin
                        win_d = arb_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!pend) begin
                    if (arb_any) begin
                        win_d = arb_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // state registers; reset drops any pending request and select
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr     <= '0;
            win_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr     <= ptr_d;
            win_q   <= win_d;
            sel_q   <= sel_d;
        end
    end

    // a grant with no outstanding request is ignored but reported
    always @(posedge clk) begin
        if (rstn) begin
            assert (!gnt_err)
            else $warning("gsa_gnt seen while gsa_req low, ignored");
        end
    end

    logic unused_gnt;
    assign unused_gnt = ^arb_gnt;

endmodule

// File: tb/tb_vc_local_switch_arbiter.sv
// Directed self-checking bench for the local VC arbiter.
// One task per scenario, each with its own inline checks.
module tb_vc_local_switch_arbiter;
    import vc_local_switch_arbiter_pkg::*;

    logic        clk;
    logic        rstn;
    logic [3:0]  vc_req;
    logic [11:0] vc_oport;
    logic        gsa_req;
    logic [2:0]  gsa_oport;
    logic        gsa_gnt;
    logic [3:0]  vc_pop;
    logic [3:0]  sel;
    logic        st_valid;

    int checks;
    int errors;

    vc_local_switch_arbiter #(
        .V  (4),
        .P  (5),
        .PW (3)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .vc_req    (vc_req),
        .vc_oport  (vc_oport),
        .gsa_req   (gsa_req),
        .gsa_oport (gsa_oport),
        .gsa_gnt   (gsa_gnt),
        .vc_pop    (vc_pop),
        .sel       (sel),
        .st_valid  (st_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        vc_req   = '0;
        vc_oport = '0;
        gsa_gnt  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        vc_req   = '0;
        vc_oport = '0;
        gsa_gnt  = 1'b0;
        tick();
        checks++;
        if (sel !== 4'b0 || vc_pop !== 4'b0 || st_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out got sel=%b pop=%b stv=%b want 0",
                     sel, vc_pop, st_valid);
        end
        checks++;
        if (gsa_req !== 1'b0 || gsa_oport !== 3'd0) begin
            errors++;
            $display("FAIL rst_req got req=%b op=%0d want 0 0",
                     gsa_req, gsa_oport);
        end
        checks++;
        if (dut.ptr !== 2'd0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL rst_state got ptr=%0d st=%b want 0 0",
                     dut.ptr, dut.state_q);
        end
        rstn   = 1'b1;
        vc_req = 4'b0011;
        tick();
        checks++;
        if (gsa_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_req got %b want 1", gsa_req);
        end
        gsa_gnt = 1'b1;
        tick();
        checks++;
        if (sel !== 4'b0001 || gsa_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_sel got sel=%b req=%b want 0001 1",
                     sel, gsa_req);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (sel !== 4'b0 || vc_pop !== 4'b0 || gsa_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got sel=%b pop=%b req=%b want 0 0 0",
                     sel, vc_pop, gsa_req);
        end
        checks++;
        if (dut.ptr !== 2'd0 || st_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ptr got ptr=%0d stv=%b want 0 0",
                     dut.ptr, st_valid);
        end
        tick();
        checks++;
        if (vc_pop !== 4'b0) begin
            errors++;
            $display("FAIL rst_nopop got %b want 0000", vc_pop);
        end
        gsa_gnt = 1'b0;
        vc_req  = '0;
        rstn    = 1'b1;
    endtask

    task automatic test_rr_pair();
        logic [3:0] exp_sel [3];
        logic [1:0] exp_ptr [3];
        exp_sel = '{4'b0010, 4'b1000, 4'b0010};
        exp_ptr = '{2'd2, 2'd0, 2'd2};
        do_reset();
        vc_req = 4'b1010;
        tick();
        checks++;
        if (gsa_req !== 1'b1 || dut.win_q !== 2'd1) begin
            errors++;
            $display("FAIL rr_first got req=%b win=%0d want 1 1",
                     gsa_req, dut.win_q);
        end
        gsa_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (sel !== exp_sel[k] || dut.ptr !== exp_ptr[k]) begin
                errors++;
                $display("FAIL rr_step%0d got sel=%b ptr=%0d want %b %0d",
                         k, sel, dut.ptr, exp_sel[k], exp_ptr[k]);
            end
        end
        gsa_gnt = 1'b0;
    endtask

    task automatic test_single_vc();
        logic [3:0] exp;
        do_reset();
        vc_req = 4'b0001;
        tick();
        gsa_gnt = gsa_req;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            checks++;
            if (sel !== exp || st_valid !== (|exp)) begin
                errors++;
                $display("FAIL single%0d got sel=%b stv=%b want %b %b",
                         k, sel, st_valid, exp, |exp);
            end
            gsa_gnt = gsa_req;
        end
        gsa_gnt = 1'b0;
    endtask

    task automatic test_withdraw();
        do_reset();
        vc_req = 4'b0010;
        tick();
        gsa_gnt = 1'b1;
        tick();
        gsa_gnt = 1'b0;
        vc_req  = 4'b0100;
        tick();
        checks++;
        if (dut.win_q !== 2'd2 || gsa_req !== 1'b1 || dut.ptr !== 2'd2) begin
            errors++;
            $display("FAIL wd_setup got win=%0d req=%b ptr=%0d want 2 1 2",
                     dut.win_q, gsa_req, dut.ptr);
        end
        vc_req = 4'b0011;
        #1;
        checks++;
        if (gsa_req !== 1'b0) begin
            errors++;
            $display("FAIL wd_req got %b want 0", gsa_req);
        end
        tick();
        checks++;
        if (dut.win_q !== 2'd0 || dut.ptr !== 2'd2) begin
            errors++;
            $display("FAIL wd_win got win=%0d ptr=%0d want 0 2",
                     dut.win_q, dut.ptr);
        end
        checks++;
        if (vc_pop !== 4'b0 || dut.state_q !== REQ || gsa_req !== 1'b1) begin
            errors++;
            $display("FAIL wd_state got pop=%b st=%b req=%b want 0000 1 1",
                     vc_pop, dut.state_q, gsa_req);
        end
    endtask

    task automatic test_oport_stale();
        do_reset();
        vc_oport = {3'd4, 3'd1, 3'd3, 3'd0};
        vc_req   = 4'b0100;
        tick();
        checks++;
        if (gsa_oport !== 3'd1 || gsa_req !== 1'b1) begin
            errors++;
            $display("FAIL op_vc2 got op=%0d req=%b want 1 1",
                     gsa_oport, gsa_req);
        end
        vc_req  = 4'b0000;
        gsa_gnt = 1'b1;
        #1;
        checks++;
        if (gsa_req !== 1'b0 || dut.gnt_err !== 1'b1) begin
            errors++;
            $display("FAIL stale_flag got req=%b err=%b want 0 1",
                     gsa_req, dut.gnt_err);
        end
        tick();
        checks++;
        if (vc_pop !== 4'b0 || sel !== 4'b0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL stale_pop got pop=%b sel=%b st=%b want 0 0 0",
                     vc_pop, sel, dut.state_q);
        end
        gsa_gnt = 1'b0;
        vc_req  = 4'b1000;
        tick();
        checks++;
        if (gsa_oport !== 3'd4 || dut.win_q !== 2'd3) begin
            errors++;
            $display("FAIL op_vc3 got op=%0d win=%0d want 4 3",
                     gsa_oport, dut.win_q);
        end
    endtask

    task automatic test_all_vcs();
        int cnt [4];
        int viol;
        cnt  = '{0, 0, 0, 0};
        viol = 0;
        do_reset();
        vc_req = 4'b1111;
        tick();
        gsa_gnt = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (vc_pop !== sel) viol++;
            if ($countones(sel) != 1) viol++;
            for (int i = 0; i < 4; i++) begin
                if (vc_pop[i] === 1'b1) cnt[i]++;
            end
        end
        gsa_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnt[i] != 25) begin
                errors++;
                $display("FAIL all_cnt vc%0d got %0d want 25", i, cnt[i]);
            end
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL all_onehot got %0d bad cycles want 0", viol);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rstn     = 1'b0;
        vc_req   = '0;
        vc_oport = '0;
        gsa_gnt  = 1'b0;
        test_reset();
        test_rr_pair();
        test_single_vc();
        test_withdraw();
        test_oport_stale();
        test_all_vcs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
